axis_rr_mux: RTL and testbench
==============================

# axis_rr_mux

Frame-aware round-robin AXI4-Stream multiplexer: merges S_COUNT input streams onto one output, granting one input per frame (tlast-delimited) and never interleaving beats of different frames. It sits upstream of the per-port demultiplexers, on the path where several packet sources funnel into one datapath. The output has a registered skid buffer for full throughput. An optional tdest tag records the source index so a downstream demux can route responses back.

## Interface
- S_COUNT, 4 — number of input streams, ≥2
- DATA_WIDTH, 8 — tdata width in bits
- KEEP_WIDTH, (DATA_WIDTH+7)/8 — tkeep width
- USER_WIDTH, 1 — tuser width
- S_DEST_WIDTH, 8 — per-input tdest width
- M_DEST_WIDTH, S_DEST_WIDTH+$clog2(S_COUNT) — output tdest width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port i at slice i
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  S_COUNT  input valid
- s_axis_tready  out  S_COUNT  input ready; at most one bit high
- s_axis_tlast  in  S_COUNT  end of frame
- s_axis_tdest  in  S_COUNT*S_DEST_WIDTH  input destination
- s_axis_tuser  in  S_COUNT*USER_WIDTH  input sideband
- m_axis_tdata/tkeep/tlast/tuser  out  DATA_WIDTH/KEEP_WIDTH/1/USER_WIDTH  output beat
- m_axis_tdest  out  M_DEST_WIDTH  output destination
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- busy  out  1  high while a frame is granted

## Operation
- FSM states: IDLE, ACTIVE. Registers: grant_idx, last_idx (reset S_COUNT-1).
- IDLE: if any s_axis_tvalid, grant the first requesting index scanning last_idx+1, last_idx+2, … modulo S_COUNT; grant_idx ← winner, last_idx ← winner, go ACTIVE. No request: stay IDLE.
- ACTIVE: s_axis_tready[grant_idx] = internal ready register; all other bits 0. Every accepted beat is forwarded unchanged to the output buffer. Accepted beat with tlast → IDLE next cycle.
- Input deasserting tvalid mid-frame: grant held; no timeout.
- Skid buffer: output register plus one temp register; internal ready register = output ready&valid, or temp empty and (output empty or no beat entering). No beat lost or duplicated under any tready pattern.
- busy = (state == ACTIVE).

## Timing
- Reset (rst_n low at clk edge): state IDLE, last_idx S_COUNT-1, m_axis_tvalid 0, s_axis_tready all 0, busy 0, temp empty; datapath registers 0. Reset mid-frame discards the frame and buffered beats.
- Arbitration: request in IDLE at cycle n → grant at n+1; first beat accepted no earlier than n+1 (tready high at n+1 given empty buffer).
- Latency: beat accepted at cycle n → m_axis_tvalid at n+1.
- Throughput: one beat/cycle within a frame when m_axis_tready held high; one idle input cycle between consecutive frames (IDLE arbitration cycle).
- Single-beat frame: granted, accepted, IDLE next cycle.
- m_axis_tvalid never drops without m_axis_tready; output signals stable while stalled.
- m_axis_tready low: at most two beats buffered, then s_axis_tready deasserts within one cycle.

## Configuration
- AXIS_RR_MUX_TDEST_TAG_EN defined: m_axis_tdest = {grant_idx, s_axis_tdest[grant_idx]} (index in the $clog2(S_COUNT) MSBs), captured per beat.
- Not defined: m_axis_tdest = {zeros, s_axis_tdest[grant_idx]}; index MSBs are 0.

## Test plan
- Reset then all four inputs valid with 3-beat frames, m_axis_tready=1 → grant order 0,1,2,3,0; 3 beats each, one-cycle gap between frames, tdata order preserved.
- Port 2 frame 0xA1,0xA2,0xA3(tlast) while port 1 asserts mid-frame → output A1,A2,A3 contiguous, then port 1's frame; no interleave.
- m_axis_tready toggled 1,0,0,1 during 8-beat frame → all 8 beats in order, no duplicates, tvalid held while stalled.
- Only port 3 requests, single-beat frames back-to-back → every frame granted to 3, tready[3] high every other cycle.
- With AXIS_RR_MUX_TDEST_TAG_EN, S_COUNT=4, port 2 tdest=0x5A → m_axis_tdest=0x25A; without it → 0x05A.
- rst_n low for one cycle mid-frame → next cycle m_axis_tvalid=0, s_axis_tready=0, busy=0; next grant starts from port 0.

Source files
------------

// File: rtl/axis_rr_mux.sv
`default_nettype none
// ============================================================================
// Module   : axis_rr_mux
// Brief    : Frame-aware round-robin AXI4-Stream mux with registered skid output.
//            Optional source-index tdest tag: define AXIS_RR_MUX_TDEST_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rr_mux #(
    parameter int S_COUNT      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH   = 1,
    parameter int S_DEST_WIDTH = 8,
    parameter int M_DEST_WIDTH = S_DEST_WIDTH + $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*S_DEST_WIDTH-1:0]  s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [M_DEST_WIDTH-1:0]          m_axis_tdest,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             busy
);

    localparam int C_IDX_W  = $clog2(S_COUNT);
    localparam int C_BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + M_DEST_WIDTH;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX_RST = C_IDX_W'(S_COUNT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [C_IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [C_IDX_W-1:0]   last_idx_q, last_idx_d;
    logic                 ready_int_q, ready_int_d;
    logic                 m_valid_q, m_valid_d;
    logic [C_BEAT_W-1:0]  m_beat_q, m_beat_d;
    logic                 tmp_valid_q, tmp_valid_d;
    logic [C_BEAT_W-1:0]  tmp_beat_q, tmp_beat_d;

    logic                     w_arb_found;
    logic [C_IDX_W-1:0]       w_arb_idx;
    logic                     w_beat_in;
    logic [DATA_WIDTH-1:0]    w_in_data;
    logic [KEEP_WIDTH-1:0]    w_in_keep;
    logic                     w_in_last;
    logic [USER_WIDTH-1:0]    w_in_user;
    logic [S_DEST_WIDTH-1:0]  w_s_dest;
    logic [M_DEST_WIDTH-1:0]  w_in_dest;
    logic [C_BEAT_W-1:0]      w_in_beat;

    function automatic logic [C_IDX_W-1:0] rr_idx(input logic [C_IDX_W-1:0] base,
                                                  input int ofs);
        logic [31:0] sum;
        sum = (32'(base) + 32'(ofs)) % 32'(S_COUNT);
        return C_IDX_W'(sum);
    endfunction

    // Scan starts just past the previous winner so every requester gets a turn.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = last_idx_q;
        for (int k = 1; k <= S_COUNT; k++) begin
            if (!w_arb_found && s_axis_tvalid[rr_idx(last_idx_q, k)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = rr_idx(last_idx_q, k);
            end
        end
    end

    assign w_in_data = s_axis_tdata[32'(grant_idx_q) * DATA_WIDTH +: DATA_WIDTH];
    assign w_in_keep = s_axis_tkeep[32'(grant_idx_q) * KEEP_WIDTH +: KEEP_WIDTH];
    assign w_in_user = s_axis_tuser[32'(grant_idx_q) * USER_WIDTH +: USER_WIDTH];
    assign w_s_dest  = s_axis_tdest[32'(grant_idx_q) * S_DEST_WIDTH +: S_DEST_WIDTH];
    assign w_in_last = s_axis_tlast[grant_idx_q];

`ifdef AXIS_RR_MUX_TDEST_TAG_EN
    assign w_in_dest = M_DEST_WIDTH'({grant_idx_q, w_s_dest});
`else
    assign w_in_dest = M_DEST_WIDTH'(w_s_dest);
`endif

    assign w_in_beat = {w_in_data, w_in_keep, w_in_last, w_in_user, w_in_dest};
    assign w_beat_in = (state_q == ACTIVE) && ready_int_q && s_axis_tvalid[grant_idx_q];

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ACTIVE) begin
            s_axis_tready[grant_idx_q] = ready_int_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            IDLE: begin
                if (w_arb_found) begin
                    grant_idx_d = w_arb_idx;
                    last_idx_d  = w_arb_idx;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_beat_in && w_in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: a beat goes straight to the output register when it is free
    // or draining, otherwise it parks in the temp register until the next drain.
    always_comb begin
        m_valid_d   = m_valid_q;
        m_beat_d    = m_beat_q;
        tmp_valid_d = tmp_valid_q;
        tmp_beat_d  = tmp_beat_q;
        ready_int_d = m_axis_tready || (!tmp_valid_q && (!m_valid_q || !w_beat_in));
        if (ready_int_q) begin
            if (m_axis_tready || !m_valid_q) begin
                m_valid_d = w_beat_in;
                if (w_beat_in) begin
                    m_beat_d = w_in_beat;
                end
            end else begin
                tmp_valid_d = w_beat_in;
                if (w_beat_in) begin
                    tmp_beat_d = w_in_beat;
                end
            end
        end else if (m_axis_tready) begin
            m_valid_d   = tmp_valid_q;
            tmp_valid_d = 1'b0;
            if (tmp_valid_q) begin
                m_beat_d = tmp_beat_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= C_LAST_IDX_RST;
            ready_int_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_beat_q    <= '0;
            tmp_valid_q <= 1'b0;
            tmp_beat_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            ready_int_q <= ready_int_d;
            m_valid_q   <= m_valid_d;
            m_beat_q    <= m_beat_d;
            tmp_valid_q <= tmp_valid_d;
            tmp_beat_q  <= tmp_beat_d;
        end
    end

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = m_beat_q;
    assign m_axis_tvalid = m_valid_q;
    assign busy          = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_rr_mux
// Brief    : Directed self-checking bench for axis_rr_mux (4 ports, 8-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_rr_mux;

    localparam int S_COUNT = 4;
    localparam int DW      = 8;
    localparam int KW      = 1;
    localparam int UW      = 1;
    localparam int SDW     = 8;
    localparam int MDW     = 10;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [S_COUNT*DW-1:0]  s_axis_tdata;
    logic [S_COUNT*KW-1:0]  s_axis_tkeep;
    logic [S_COUNT-1:0]     s_axis_tvalid;
    logic [S_COUNT-1:0]     s_axis_tready;
    logic [S_COUNT-1:0]     s_axis_tlast;
    logic [S_COUNT*SDW-1:0] s_axis_tdest;
    logic [S_COUNT*UW-1:0]  s_axis_tuser;
    logic [DW-1:0]          m_axis_tdata;
    logic [KW-1:0]          m_axis_tkeep;
    logic                   m_axis_tlast;
    logic [UW-1:0]          m_axis_tuser;
    logic [MDW-1:0]         m_axis_tdest;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   busy;

    always #5 clk = ~clk;

    axis_rr_mux #(
        .S_COUNT(S_COUNT), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
        .S_DEST_WIDTH(SDW), .M_DEST_WIDTH(MDW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tdest(m_axis_tdest), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy)
    );

    // Source frame storage and output/accept logs
    logic [7:0]     src_data [S_COUNT][16];
    logic           src_last [S_COUNT][16];
    logic [7:0]     src_dest [S_COUNT];
    int             src_len  [S_COUNT];
    int             src_ptr  [S_COUNT];
    logic           src_en   [S_COUNT];

    logic [7:0]     out_data [64];
    logic           out_last [64];
    logic [MDW-1:0] out_dest [64];
    int             out_cyc  [64];
    int             out_cnt;
    int             acc_port [64];
    int             acc_cyc  [64];
    int             acc_cnt;

    int             cyc;
    int             stall_viol;
    int             stall_seen;
    int             max_occ;
    logic           prev_stall;
    logic [7:0]     prev_data;
    int             n_checks;
    int             n_fail;

    task automatic drive();
        for (int i = 0; i < S_COUNT; i++) begin
            if (src_en[i] && src_ptr[i] < src_len[i]) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*DW +: DW]  = src_data[i][src_ptr[i]];
                s_axis_tlast[i]           = src_last[i][src_ptr[i]];
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW]  = '0;
                s_axis_tlast[i]           = 1'b0;
            end
            s_axis_tdest[i*SDW +: SDW] = src_dest[i];
        end
    endtask

    task automatic clear_logs();
        out_cnt    = 0;
        acc_cnt    = 0;
        stall_viol = 0;
        stall_seen = 0;
        max_occ    = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < S_COUNT; i++) begin
            src_len[i]  = 0;
            src_ptr[i]  = 0;
            src_en[i]   = 1'b0;
            src_dest[i] = 8'(8'h50 + i);
        end
    endtask

    task automatic load_frame(input int port, input int base, input int n);
        for (int j = 0; j < n; j++) begin
            src_data[port][src_len[port] + j] = 8'(base + j);
            src_last[port][src_len[port] + j] = (j == n - 1);
        end
        src_len[port] = src_len[port] + n;
    endtask

    // One clock: log handshakes at the falling edge, advance sources after the rising edge.
    task automatic step();
        logic [S_COUNT-1:0] taken;
        @(negedge clk);
        taken = s_axis_tvalid & s_axis_tready;
        for (int i = 0; i < S_COUNT; i++) begin
            if (taken[i] && acc_cnt < 64) begin
                acc_port[acc_cnt] = i;
                acc_cyc[acc_cnt]  = cyc;
                acc_cnt++;
            end
        end
        if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data)) stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (prev_stall) stall_seen++;
        if (m_axis_tvalid && m_axis_tready && out_cnt < 64) begin
            out_data[out_cnt] = m_axis_tdata;
            out_last[out_cnt] = m_axis_tlast;
            out_dest[out_cnt] = m_axis_tdest;
            out_cyc[out_cnt]  = cyc;
            out_cnt++;
        end
        if (acc_cnt - out_cnt > max_occ) max_occ = acc_cnt - out_cnt;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < S_COUNT; i++) begin
            if (taken[i]) src_ptr[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        m_axis_tready = 1'b1;
        clear_src();
        drive();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        m_axis_tready = 1'b1;
        clear_src();
        drive();
        step();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
        n_checks++;
        if (s_axis_tready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_tready: got %b expected 0000", s_axis_tready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (m_axis_tdata !== 8'h00 || m_axis_tdest !== 10'h000) begin
            n_fail++; $display("FAIL reset_datapath: got data %h dest %h expected 00/000",
                               m_axis_tdata, m_axis_tdest);
        end
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [15] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21,
                                   8'h22, 8'h30, 8'h31, 8'h32, 8'h04, 8'h05, 8'h06};
        int c0;
        do_reset();
        load_frame(0, 8'h00, 3);
        load_frame(0, 8'h04, 3);
        load_frame(1, 8'h10, 3);
        load_frame(2, 8'h20, 3);
        load_frame(3, 8'h30, 3);
        for (int i = 0; i < S_COUNT; i++) src_en[i] = 1'b1;
        drive();
        c0 = cyc;
        repeat (25) step();
        n_checks++;
        if (out_cnt != 15 || acc_cnt != 15) begin
            n_fail++; $display("FAIL rr_count: got out %0d acc %0d expected 15/15", out_cnt, acc_cnt);
        end
        n_checks++;
        if (acc_cyc[0] != c0 + 1) begin
            n_fail++; $display("FAIL rr_first_grant: got cycle %0d expected %0d", acc_cyc[0], c0 + 1);
        end
        for (int k = 0; k < 15 && k < out_cnt && k < acc_cnt; k++) begin
            n_checks++;
            if (out_data[k] !== exp_d[k] || out_last[k] !== (k % 3 == 2)) begin
                n_fail++; $display("FAIL rr_beat%0d: got data %h last %b expected %h %b",
                                   k, out_data[k], out_last[k], exp_d[k], (k % 3 == 2));
            end
            n_checks++;
            if (acc_cyc[k] - acc_cyc[0] != (k / 3) * 4 + k % 3 || out_cyc[k] != acc_cyc[k] + 1) begin
                n_fail++; $display("FAIL rr_timing%0d: got acc +%0d out lat %0d expected +%0d lat 1",
                                   k, acc_cyc[k] - acc_cyc[0], out_cyc[k] - acc_cyc[k],
                                   (k / 3) * 4 + k % 3);
            end
        end
    endtask

    task automatic test_no_interleave();
        logic [7:0] exp_d [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
        do_reset();
        load_frame(2, 8'hA1, 3);
        load_frame(1, 8'hB1, 2);
        src_en[2] = 1'b1;
        drive();
        step();
        step();
        src_en[1] = 1'b1;
        drive();
        repeat (10) step();
        n_checks++;
        if (out_cnt != 5) begin
            n_fail++; $display("FAIL ni_count: got %0d expected 5", out_cnt);
        end
        for (int k = 0; k < 5 && k < out_cnt; k++) begin
            n_checks++;
            if (out_data[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL ni_beat%0d: got %h expected %h", k, out_data[k], exp_d[k]);
            end
        end
        n_checks++;
        if (out_cnt >= 3 && out_cyc[2] - out_cyc[0] != 2) begin
            n_fail++; $display("FAIL ni_contiguous: got span %0d expected 2", out_cyc[2] - out_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_frame(0, 8'h80, 8);
        src_en[0] = 1'b1;
        drive();
        for (int i = 0; i < 40; i++) begin
            m_axis_tready = pat[i % 4];
            step();
        end
        m_axis_tready = 1'b1;
        n_checks++;
        if (out_cnt != 8 || acc_cnt != 8) begin
            n_fail++; $display("FAIL bp_count: got out %0d acc %0d expected 8/8", out_cnt, acc_cnt);
        end
        for (int k = 0; k < 8 && k < out_cnt; k++) begin
            n_checks++;
            if (out_data[k] !== 8'(8'h80 + k) || out_last[k] !== (k == 7)) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h last %b expected %h %b",
                                   k, out_data[k], out_last[k], 8'(8'h80 + k), (k == 7));
            end
        end
        n_checks++;
        if (stall_viol != 0 || stall_seen == 0) begin
            n_fail++; $display("FAIL bp_stall_hold: got %0d violations over %0d stalls expected 0 over >0",
                               stall_viol, stall_seen);
        end
        n_checks++;
        if (max_occ > 2) begin
            n_fail++; $display("FAIL bp_occupancy: got %0d buffered expected <=2", max_occ);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int j = 0; j < 4; j++) load_frame(3, 8'hC0 + j, 1);
        src_en[3] = 1'b1;
        drive();
        repeat (14) step();
        n_checks++;
        if (out_cnt != 4 || acc_cnt != 4) begin
            n_fail++; $display("FAIL sb_count: got out %0d acc %0d expected 4/4", out_cnt, acc_cnt);
        end
        for (int k = 0; k < 4 && k < acc_cnt && k < out_cnt; k++) begin
            n_checks++;
            if (acc_port[k] != 3 || acc_cyc[k] - acc_cyc[0] != 2 * k || out_data[k] !== 8'(8'hC0 + k)) begin
                n_fail++; $display("FAIL sb_frame%0d: got port %0d +%0d data %h expected 3 +%0d %h",
                                   k, acc_port[k], acc_cyc[k] - acc_cyc[0], out_data[k],
                                   2 * k, 8'(8'hC0 + k));
            end
        end
    endtask

    task automatic test_tdest();
        logic [MDW-1:0] exp_dest;
        int c0;
`ifdef AXIS_RR_MUX_TDEST_TAG_EN
        exp_dest = 10'h25A;
`else
        exp_dest = 10'h05A;
`endif
        do_reset();
        src_dest[2] = 8'h5A;
        load_frame(2, 8'h77, 1);
        src_en[2] = 1'b1;
        drive();
        c0 = cyc;
        repeat (6) step();
        n_checks++;
        if (out_cnt != 1) begin
            n_fail++; $display("FAIL td_count: got %0d expected 1", out_cnt);
        end else begin
            n_checks++;
            if (out_dest[0] !== exp_dest || out_data[0] !== 8'h77) begin
                n_fail++; $display("FAIL td_dest: got dest %h data %h expected %h 77",
                                   out_dest[0], out_data[0], exp_dest);
            end
            n_checks++;
            if (out_cyc[0] != c0 + 2) begin
                n_fail++; $display("FAIL td_latency: got cycle %0d expected %0d", out_cyc[0], c0 + 2);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_d [4] = '{8'hD0, 8'hD1, 8'hE0, 8'hE1};
        do_reset();
        load_frame(1, 8'h10, 6);
        src_en[1] = 1'b1;
        drive();
        repeat (4) step();
        rst_n = 1'b0;
        for (int i = 0; i < S_COUNT; i++) src_en[i] = 1'b0;
        drive();
        step();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rm_state: got tvalid %b tready %b busy %b expected 0 0000 0",
                               m_axis_tvalid, s_axis_tready, busy);
        end
        rst_n = 1'b1;
        clear_src();
        clear_logs();
        load_frame(0, 8'hD0, 2);
        load_frame(2, 8'hE0, 2);
        src_en[0] = 1'b1;
        src_en[2] = 1'b1;
        drive();
        repeat (12) step();
        n_checks++;
        if (acc_cnt < 1 || acc_port[0] != 0) begin
            n_fail++; $display("FAIL rm_first_port: got %0d accepts first port %0d expected port 0",
                               acc_cnt, acc_port[0]);
        end
        n_checks++;
        if (out_cnt != 4) begin
            n_fail++; $display("FAIL rm_count: got %0d expected 4", out_cnt);
        end
        for (int k = 0; k < 4 && k < out_cnt; k++) begin
            n_checks++;
            if (out_data[k] !== exp_d[k]) begin
                n_fail++; $display("FAIL rm_beat%0d: got %h expected %h", k, out_data[k], exp_d[k]);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tkeep  = '1;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tdest  = '0;
        clear_src();
        clear_logs();
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_single_beat();
        test_tdest();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
